// File: rtl/tone_gen.sv
// tone_gen: square-wave tone generator. Converts a note frequency in Hz into a
// half-period in clock cycles using an iterative restoring divider, then drives
// a square wave whose frequency changes only at half-period boundaries.
module tone_gen #(
    parameter int CLK_HZ = 100_000_000,
    parameter int DIV_W  = 26
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] freq,
    output logic        audio_out,
    output logic        audio_sd,
    output logic        busy
);

    localparam logic [DIV_W-1:0] DIVIDEND = DIV_W'(CLK_HZ / 2);
    localparam int               ITER_W   = $clog2(DIV_W + 1);

    typedef enum logic [0:0] {MUTE, RUN} state_t;

    // Input capture and the value last handed to the divider.
    logic [11:0]       freq_q;
    logic [11:0]       freq_tgt;
    logic              accept;

    // Divider state. freq_tgt doubles as the divisor while a divide runs.
    logic [11:0]       rem;
    logic [DIV_W-1:0]  quot;
    logic [ITER_W-1:0] iter;
    logic [12:0]       rem_shift;
    logic              rem_ge;
    logic [11:0]       rem_step;
    logic [DIV_W-1:0]  quot_step;
    logic              div_done;

    // Single-entry pending request: either a new half-period or a mute.
    logic [DIV_W-1:0]  half_pend;
    logic              pend_valid;
    logic              pend_mute;
    logic              pend_tone;
    logic              pend_take;

    // Tone output state.
    state_t            state, state_next;
    logic [DIV_W-1:0]  cnt, cnt_next;
    logic [DIV_W-1:0]  half, half_next;
    logic              audio_next;
    logic              sd_next;

    assign accept = (freq_q != freq_tgt);

    // One restoring-division step: shift in the next dividend bit, subtract if it fits.
    assign rem_shift = {rem, quot[DIV_W-1]};
    assign rem_ge    = (rem_shift >= {1'b0, freq_tgt});
    assign rem_step  = rem_ge ? 12'(rem_shift - {1'b0, freq_tgt}) : rem_shift[11:0];
    assign quot_step = {quot[DIV_W-2:0], rem_ge};
    assign div_done  = busy && !accept && (iter == ITER_W'(1));

    // Input register, change acceptance and the iterative divider (a new accept aborts any divide).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            freq_q   <= '0;
            freq_tgt <= '0;
            rem      <= '0;
            quot     <= '0;
            iter     <= '0;
            busy     <= 1'b0;
        end else begin
            freq_q <= freq;
            if (accept) begin
                freq_tgt <= freq_q;
                rem      <= '0;
                quot     <= DIVIDEND;
                iter     <= ITER_W'(DIV_W);
                busy     <= (freq_q != 12'd0);
            end else if (busy) begin
                rem  <= rem_step;
                quot <= quot_step;
                iter <= iter - ITER_W'(1);
                if (iter == ITER_W'(1)) begin
                    busy <= 1'b0;
                end
            end
        end
    end

    // Pending slot: a fresh write wins over a same-cycle consume, so it lands at the next boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            half_pend  <= '0;
            pend_valid <= 1'b0;
            pend_mute  <= 1'b0;
        end else if (accept && (freq_q == 12'd0)) begin
            pend_valid <= 1'b1;
            pend_mute  <= 1'b1;
        end else if (div_done) begin
            half_pend  <= quot_step;
            pend_valid <= 1'b1;
            pend_mute  <= 1'b0;
        end else if (pend_take) begin
            pend_valid <= 1'b0;
        end
    end

    assign pend_tone = pend_valid && !pend_mute && (half_pend != '0);

    // Output FSM state and registered audio lines.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= MUTE;
            cnt       <= '0;
            half      <= '0;
            audio_out <= 1'b0;
            audio_sd  <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            half      <= half_next;
            audio_out <= audio_next;
            audio_sd  <= sd_next;
        end
    end

    // Next-state logic: start from MUTE immediately, otherwise change only at a half-period boundary.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        half_next  = half;
        audio_next = audio_out;
        sd_next    = audio_sd;
        pend_take  = 1'b0;
        case (state)
            MUTE: begin
                cnt_next   = '0;
                audio_next = 1'b0;
                sd_next    = 1'b0;
                if (pend_valid) begin
                    pend_take = 1'b1;
                    if (pend_tone) begin
                        half_next  = half_pend;
                        audio_next = 1'b1;
                        sd_next    = 1'b1;
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                if (cnt == half - DIV_W'(1)) begin
                    cnt_next = '0;
                    if (pend_valid) begin
                        pend_take = 1'b1;
                        if (pend_tone) begin
                            half_next  = half_pend;
                            audio_next = ~audio_out;
                        end else begin
                            audio_next = 1'b0;
                            sd_next    = 1'b0;
                            state_next = MUTE;
                        end
                    end else begin
                        audio_next = ~audio_out;
                    end
                end else begin
                    cnt_next = cnt + DIV_W'(1);
                end
            end
            default: begin
                state_next = MUTE;
            end
        endcase
    end

endmodule

// File: tb/tb_tone_gen.sv
// Self-checking bench for tone_gen with a small clock (1 MHz) and 20-bit divider.
module tb_tone_gen;

    localparam int CLK_HZ = 1_000_000;
    localparam int DIV_W  = 20;

    logic        clk;
    logic        rst_n;
    logic [11:0] freq;
    logic        audio_out;
    logic        audio_sd;
    logic        busy;

    int total = 0;
    int bad   = 0;

    tone_gen #(.CLK_HZ(CLK_HZ), .DIV_W(DIV_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .freq      (freq),
        .audio_out (audio_out),
        .audio_sd  (audio_sd),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int    f;
        longint half;
    } vec_t;

    // Reference: half-period is the integer quotient of half the clock rate by the tone frequency.
    function automatic longint model_half(input int f);
        return longint'(CLK_HZ / 2) / longint'(f);
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic wait_edges(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Count cycles until audio_out (sel=0) or audio_sd (sel=1) changes, bounded by limit.
    task automatic wait_change(input bit sel, input int limit, output int n);
        logic start;
        start = sel ? audio_sd : audio_out;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (((sel ? audio_sd : audio_out) == start) && (n < limit));
    endtask

    vec_t tbl [7];
    int   n;
    int   highs;
    int   last_f;
    int   rf;

    initial begin
        tbl[0] = '{440, 1136};
        tbl[1] = '{880, 568};
        tbl[2] = '{523, 956};
        tbl[3] = '{587, 851};
        tbl[4] = '{1, 500000};
        tbl[5] = '{4095, 122};
        tbl[6] = '{659, 758};

        // Reset state
        rst_n = 1'b0;
        freq  = 12'd0;
        wait_edges(3);
        check("reset audio_out", audio_out, 0);
        check("reset audio_sd", audio_sd, 0);
        check("reset busy", busy, 0);

        // 440 Hz from reset: latency and level length
        rst_n = 1'b1;
        freq  = 12'd440;
        wait_edges(2);
        check("440 busy at E1", busy, 1);
        wait_edges(19);
        check("440 busy at E20", busy, 1);
        wait_edges(1);
        check("440 busy at E21", busy, 0);
        check("440 half_pend", dut.half_pend, model_half(440));
        check("440 audio at E21", audio_out, 0);
        wait_edges(1);
        check("440 audio at E22", audio_out, 1);
        check("440 sd at E22", audio_sd, 1);
        wait_change(0, 5000, n);
        check("440 high level", n, model_half(440));
        wait_change(0, 5000, n);
        check("440 low level", n, model_half(440));
        check("440 sd steady", audio_sd, 1);

        // Switch to 880 mid-level: current level completes, then shorter levels
        wait_edges(300);
        freq = 12'd880;
        wait_change(0, 5000, n);
        check("440->880 finishing level", 300 + n, model_half(440));
        wait_change(0, 5000, n);
        check("880 level 1", n, model_half(880));
        wait_change(0, 5000, n);
        check("880 level 2", n, model_half(880));

        // Mute while running: level finishes, then silence
        wait_edges(100);
        freq = 12'd0;
        wait_change(1, 5000, n);
        check("mute at boundary", 100 + n, model_half(880));
        check("mute audio_out", audio_out, 0);
        highs = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (audio_out || audio_sd) highs++;
        end
        check("mute stays silent", highs, 0);

        // Rapid changes during divide: only the newest applies
        freq = 12'd440;
        wait_edges(2);
        check("burst busy after 440", busy, 1);
        wait_edges(3);
        freq = 12'd523;
        wait_edges(5);
        freq = 12'd587;
        wait_edges(2);
        check("burst busy at E1", busy, 1);
        wait_edges(19);
        check("burst busy at E20", busy, 1);
        check("burst audio silent", audio_out, 0);
        wait_edges(1);
        check("burst busy at E21", busy, 0);
        check("burst half_pend", dut.half_pend, model_half(587));
        wait_edges(1);
        check("burst audio at E22", audio_out, 1);
        wait_change(0, 5000, n);
        check("587 level", n, model_half(587));

        // Full-width quotient with freq=1, from MUTE
        freq = 12'd0;
        wait_change(1, 3000, n);
        check("mute before freq=1", audio_sd, 0);
        freq = 12'd1;
        wait_edges(22);
        check("freq=1 half_pend", dut.half_pend, model_half(1));
        wait_edges(1);
        check("freq=1 audio at E22", audio_out, 1);
        check("freq=1 half", dut.half, model_half(1));

        // Reset mid-tone: outputs drop without waiting for a clock edge
        wait_edges(50);
        #2;
        rst_n = 1'b0;
        freq  = 12'd4095;
        #1;
        check("rst mid-tone audio_out", audio_out, 0);
        check("rst mid-tone audio_sd", audio_sd, 0);
        check("rst mid-tone busy", busy, 0);
        wait_edges(3);
        rst_n = 1'b1;
        wait_edges(22);
        check("4095 half_pend", dut.half_pend, model_half(4095));
        wait_edges(1);
        check("4095 audio at E22", audio_out, 1);
        for (int k = 0; k < 3; k++) begin
            wait_change(0, 1000, n);
            check("4095 level", n, model_half(4095));
        end

        // Reset mid-divide, then restart with 659
        freq = 12'd659;
        wait_edges(5);
        check("659 busy before reset", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst mid-divide busy", busy, 0);
        check("rst mid-divide audio_out", audio_out, 0);
        check("rst mid-divide audio_sd", audio_sd, 0);
        wait_edges(3);
        rst_n = 1'b1;
        wait_edges(22);
        check("659 busy at E21", busy, 0);
        check("659 half_pend", dut.half_pend, model_half(659));
        wait_edges(1);
        check("659 audio at E22", audio_out, 1);
        wait_change(0, 2000, n);
        check("659 level", n, model_half(659));

        // Randomized frequencies checked against the reference quotient
        last_f = 659;
        for (int k = 0; k < 8; k++) begin
            do rf = int'($urandom_range(500, 4095)); while (rf == last_f);
            freq = 12'(rf);
            wait_edges(2);
            check($sformatf("rand f=%0d busy at E1", rf), busy, 1);
            wait_edges(20);
            check($sformatf("rand f=%0d busy at E21", rf), busy, 0);
            check($sformatf("rand f=%0d half_pend", rf), dut.half_pend, model_half(rf));
            last_f = rf;
        end
        wait_change(0, 3000, n);
        wait_change(0, 3000, n);
        check($sformatf("rand f=%0d level", last_f), n, model_half(last_f));

        // Table of known quotients
        freq = 12'd0;
        wait_edges(3);
        for (int k = 0; k < 7; k++) begin
            freq = 12'(tbl[k].f);
            wait_edges(22);
            check($sformatf("table f=%0d busy", tbl[k].f), busy, 0);
            check($sformatf("table f=%0d half_pend", tbl[k].f), dut.half_pend, tbl[k].half);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
